// File: rtl/ibex_pad_bridge.sv
// Serializes ibex instruction/data requests onto a narrow pad bus (header, address, write data) and reassembles read responses; one transaction in flight.
// Optional feature macro IBEX_PAD_PARITY_EN adds even parity on outbound and inbound pad beats.
module ibex_pad_bridge #(
  parameter int PAD_W   = 8,
  parameter int ARB_RR  = 0,
  parameter int TIMEOUT = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  input  logic             data_req_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  output logic [PAD_W-1:0] pad_out_o,
  output logic             pad_out_valid_o,
  input  logic             pad_out_ready_i,
`ifdef IBEX_PAD_PARITY_EN
  output logic             pad_out_par_o,
  input  logic             pad_in_par_i,
`endif
  input  logic [PAD_W-1:0] pad_in_i,
  input  logic             pad_in_valid_i
);
  localparam int HDR_BEATS  = (PAD_W >= 8) ? 1 : 2;
  localparam int WORD_BEATS = 32 / PAD_W;

  if (PAD_W != 4 && PAD_W != 8 && PAD_W != 16 && PAD_W != 32) begin : g_bad_pad_w
    $error("ibex_pad_bridge: PAD_W must be 4, 8, 16 or 32");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("ibex_pad_bridge: TIMEOUT must be in 2..65535");
  end

  typedef enum logic [2:0] {IDLE, HDR, ADDR, WDATA, RESP, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] tcnt_q;
  logic        chan_q, we_q, last_data_q, rvalid_q, err_q, par_err_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  logic        sel_data, grant, fire, hdr_last, word_last, beat_bad, resp_err, ld;
  logic [7:0]  hdr_new;
  logic [31:0] hdr_word, ld_word, rdata_nxt;
  logic [3:0]  ld_idx;
  logic [PAD_W-1:0] ld_beat;

  function automatic logic [PAD_W-1:0] beat_of(input logic [31:0] word, input logic [3:0] idx);
    return PAD_W'(word >> (32'(idx) * 32'(PAD_W)));
  endfunction

  // Round-robin only matters under contention; the pointer records the last granted channel.
  assign sel_data    = data_req_i && (ARB_RR == 0 || !instr_req_i || !last_data_q);
  assign instr_gnt_o = (state_q == IDLE) && instr_req_i && !sel_data;
  assign data_gnt_o  = (state_q == IDLE) && sel_data;
  assign grant       = instr_gnt_o || data_gnt_o;

  assign hdr_new   = {2'b00, sel_data ? data_be_i : 4'b1111, sel_data, sel_data && data_we_i};
  assign hdr_word  = {24'b0, 2'b00, be_q, chan_q, we_q};
  assign fire      = pad_out_valid_o && pad_out_ready_i;
  assign hdr_last  = (cnt_q == 4'(HDR_BEATS - 1));
  assign word_last = (cnt_q == 4'(WORD_BEATS - 1));

  if (PAD_W == 32) begin : g_rd_full
    assign rdata_nxt = pad_in_i;
  end else begin : g_rd_shift
    assign rdata_nxt = {pad_in_i, rdata_q[31:PAD_W]};
  end

`ifdef IBEX_PAD_PARITY_EN
  assign beat_bad = (^pad_in_i) != pad_in_par_i;
`else
  assign beat_bad = 1'b0;
`endif
  assign resp_err = par_err_q || beat_bad;

  // Next outbound beat, loaded into the output register only when the current one is taken.
  always_comb begin
    ld      = 1'b0;
    ld_word = hdr_word;
    ld_idx  = cnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        ld      = grant;
        ld_word = {24'b0, hdr_new};
        ld_idx  = 4'd0;
      end
      HDR: begin
        ld = fire;
        if (hdr_last) begin
          ld_word = addr_q;
          ld_idx  = 4'd0;
        end
      end
      ADDR: begin
        if (word_last) begin
          ld      = fire && we_q;
          ld_word = wdata_q;
          ld_idx  = 4'd0;
        end else begin
          ld      = fire;
          ld_word = addr_q;
        end
      end
      WDATA: begin
        ld      = fire && !word_last;
        ld_word = wdata_q;
      end
      default: ;
    endcase
  end
  assign ld_beat = beat_of(ld_word, ld_idx);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      tcnt_q          <= '0;
      chan_q          <= 1'b0;
      we_q            <= 1'b0;
      be_q            <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      last_data_q     <= 1'b0;
      rvalid_q        <= 1'b0;
      err_q           <= 1'b0;
      par_err_q       <= 1'b0;
      pad_out_o       <= '0;
      pad_out_valid_o <= 1'b0;
`ifdef IBEX_PAD_PARITY_EN
      pad_out_par_o   <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      if (ld) begin
        pad_out_o     <= ld_beat;
`ifdef IBEX_PAD_PARITY_EN
        pad_out_par_o <= ^ld_beat;
`endif
      end
      case (state_q)
        IDLE: if (grant) begin
          chan_q          <= sel_data;
          we_q            <= sel_data && data_we_i;
          be_q            <= sel_data ? data_be_i : 4'b1111;
          addr_q          <= sel_data ? data_addr_i : instr_addr_i;
          wdata_q         <= sel_data ? data_wdata_i : 32'h0;
          last_data_q     <= sel_data;
          rdata_q         <= '0;
          err_q           <= 1'b0;
          par_err_q       <= 1'b0;
          cnt_q           <= '0;
          pad_out_valid_o <= 1'b1;
          state_q         <= HDR;
        end
        HDR: if (fire) begin
          cnt_q <= hdr_last ? 4'd0 : cnt_q + 4'd1;
          if (hdr_last) state_q <= ADDR;
        end
        ADDR: if (fire) begin
          cnt_q <= word_last ? 4'd0 : cnt_q + 4'd1;
          if (word_last) begin
            if (we_q) begin
              state_q <= WDATA;
            end else begin
              pad_out_valid_o <= 1'b0;
              tcnt_q          <= '0;
              state_q         <= RESP;
            end
          end
        end
        WDATA: if (fire) begin
          cnt_q <= word_last ? 4'd0 : cnt_q + 4'd1;
          if (word_last) begin
            pad_out_valid_o <= 1'b0;
            rvalid_q        <= 1'b1;
            state_q         <= DONE;
          end
        end
        RESP: begin
          if (pad_in_valid_i) begin
            tcnt_q    <= '0;
            par_err_q <= resp_err;
            if (word_last) begin
              // A parity error still drains every beat, then reports with zero data.
              rdata_q  <= resp_err ? 32'h0 : rdata_nxt;
              err_q    <= resp_err;
              rvalid_q <= 1'b1;
              cnt_q    <= '0;
              state_q  <= DONE;
            end else begin
              rdata_q <= rdata_nxt;
              cnt_q   <= cnt_q + 4'd1;
            end
          end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
            rdata_q  <= '0;
            err_q    <= 1'b1;
            rvalid_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= DONE;
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_rvalid_o = rvalid_q && !chan_q;
  assign data_rvalid_o  = rvalid_q && chan_q;
  assign instr_rdata_o  = instr_rvalid_o ? rdata_q : 32'h0;
  assign data_rdata_o   = data_rvalid_o ? rdata_q : 32'h0;
  assign instr_err_o    = instr_rvalid_o && err_q;
  assign data_err_o     = data_rvalid_o && err_q;
endmodule

// File: tb/tb_ibex_pad_bridge.sv
// Scoreboard bench for ibex_pad_bridge: expected pad beats and responses are queued at stimulus time and checked as the DUT emits them.
module tb_ibex_pad_bridge;
  localparam int PAD_W   = 8;
  localparam int ARB_RR  = 1;
  localparam int TIMEOUT = 16;
  localparam int NB      = 32 / PAD_W;
  localparam int HB      = (PAD_W >= 8) ? 1 : 2;

  typedef struct packed {
    logic        chan;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0]      instr_addr, instr_rdata;
  logic             data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [3:0]       data_be;
  logic [31:0]      data_addr, data_wdata, data_rdata;
  logic [PAD_W-1:0] pad_out, pad_in;
  logic             pad_out_valid, pad_out_ready, pad_in_valid;
  logic             par_flip;
`ifdef IBEX_PAD_PARITY_EN
  logic             pad_out_par, pad_in_par;
  assign pad_in_par = (^pad_in) ^ par_flip;
`endif

  always #5 clk = ~clk;

  ibex_pad_bridge #(.PAD_W(PAD_W), .ARB_RR(ARB_RR), .TIMEOUT(TIMEOUT)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .pad_out_o(pad_out), .pad_out_valid_o(pad_out_valid), .pad_out_ready_i(pad_out_ready),
`ifdef IBEX_PAD_PARITY_EN
    .pad_out_par_o(pad_out_par), .pad_in_par_i(pad_in_par),
`endif
    .pad_in_i(pad_in), .pad_in_valid_i(pad_in_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats_seen = 0;
  int resp_seen = 0;
  int rv_cyc = 0;
  logic [PAD_W-1:0] exp_beats[$];
  resp_t            exp_resp[$];
  logic [PAD_W-1:0] hold_beat;
  logic             hold_vld = 1'b0;
  resp_t            r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void push_req(input logic chan, input logic we, input logic [3:0] be,
                                   input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] h;
    h = {24'b0, 2'b00, be, chan, we};
    for (int i = 0; i < HB; i++) exp_beats.push_back(h[i*PAD_W +: PAD_W]);
    for (int i = 0; i < NB; i++) exp_beats.push_back(addr[i*PAD_W +: PAD_W]);
    if (we) for (int i = 0; i < NB; i++) exp_beats.push_back(wdata[i*PAD_W +: PAD_W]);
  endfunction

  function automatic void push_resp(input logic chan, input logic err, input logic [31:0] rdata);
    resp_t e;
    e.chan = chan; e.err = err; e.rdata = rdata;
    exp_resp.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("stall_vld", 32'(pad_out_valid), 1);
        chk("stall_beat", 32'(pad_out), 32'(hold_beat));
      end
      hold_vld  = pad_out_valid && !pad_out_ready;
      hold_beat = pad_out;
      if (pad_out_valid && pad_out_ready) begin
        beats_seen++;
        chk("beat_avail", 32'(exp_beats.size() != 0), 1);
        if (exp_beats.size() != 0) chk("beat", 32'(pad_out), 32'(exp_beats.pop_front()));
`ifdef IBEX_PAD_PARITY_EN
        chk("beat_par", 32'(pad_out_par), 32'(^pad_out));
`endif
      end
      if (instr_rvalid || data_rvalid) begin
        resp_seen++;
        rv_cyc = cyc;
        chk("rvalid_both", 32'(instr_rvalid && data_rvalid), 0);
        chk("resp_avail", 32'(exp_resp.size() != 0), 1);
        if (exp_resp.size() != 0) begin
          r = exp_resp.pop_front();
          chk("resp_chan", 32'(data_rvalid), 32'(r.chan));
          chk("resp_rdata", data_rvalid ? data_rdata : instr_rdata, r.rdata);
          chk("resp_err", 32'(data_rvalid ? data_err : instr_err), 32'(r.err));
        end
      end
    end
  end

  task automatic wait_gnt(output logic gi, output logic gd);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_gnt && !data_gnt && n < 100);
    gi = instr_gnt;
    gd = data_gnt;
    chk("gnt_seen", 32'(gi || gd), 1);
  endtask

  task automatic issue(input logic chan, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, output int gcyc);
    logic gi, gd;
    if (chan) begin
      data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wdata;
    end else begin
      instr_req = 1'b1; instr_addr = addr;
    end
    wait_gnt(gi, gd);
    chk("gnt_chan", 32'(gd), 32'(chan));
    gcyc = cyc;
    @(posedge clk); #1;
    if (chan) data_req = 1'b0; else instr_req = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats_seen < target && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk("beat_wait", 32'(beats_seen >= target), 1);
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_seen < target && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk("resp_wait", 32'(resp_seen >= target), 1);
  endtask

  task automatic respond(input logic [31:0] w, input int flip_beat, input int gap);
    for (int i = 0; i < NB; i++) begin
      @(posedge clk); #1;
      pad_in_valid = 1'b1;
      pad_in       = w[i*PAD_W +: PAD_W];
      par_flip     = (i == flip_beat);
      if (gap > 0) begin
        @(posedge clk); #1;
        pad_in_valid = 1'b0;
        repeat (gap - 1) @(posedge clk);
      end
    end
    @(posedge clk); #1;
    pad_in_valid = 1'b0; pad_in = '0; par_flip = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, b0, r0, c0;
    logic gi, gd;
    rst_n = 1'b0; instr_req = 1'b0; instr_addr = '0; data_req = 1'b0; data_we = 1'b0;
    data_be = '0; data_addr = '0; data_wdata = '0; pad_out_ready = 1'b1;
    pad_in = '0; pad_in_valid = 1'b0; par_flip = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_pad_vld", 32'(pad_out_valid), 0);
    chk("rst_pad_out", 32'(pad_out), 0);
    chk("rst_rvalid", 32'({instr_rvalid, data_rvalid}), 0);
    chk("rst_rdata", instr_rdata | data_rdata, 0);
    chk("rst_err", 32'({instr_err, data_err}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: pointer starts at instr so data wins, then instr wins the next tie.
    b0 = beats_seen; r0 = resp_seen;
    push_req(1, 1, 4'h3, 32'h2000, 32'h11223344); push_resp(1, 0, 32'h0);
    push_req(0, 0, 4'hF, 32'h40, 32'h0);          push_resp(0, 0, 32'h0BADF00D);
    push_req(1, 1, 4'hC, 32'h3000, 32'h55667788); push_resp(1, 0, 32'h0);
    instr_req = 1'b1; instr_addr = 32'h40;
    data_req = 1'b1; data_we = 1'b1; data_be = 4'h3; data_addr = 32'h2000; data_wdata = 32'h11223344;
    wait_gnt(gi, gd);
    chk("rr1_data", 32'(gd), 1);
    chk("rr1_instr_lo", 32'(gi), 0);
    @(posedge clk); #1;
    data_be = 4'hC; data_addr = 32'h3000; data_wdata = 32'h55667788;
    wait_resp(r0 + 1);
    wait_gnt(gi, gd);
    chk("rr2_instr", 32'(gi), 1);
    chk("rr2_data_lo", 32'(gd), 0);
    @(posedge clk); #1;
    instr_req = 1'b0;
    wait_beats(b0 + 2*HB + 3*NB);
    respond(32'h0BADF00D, -1, 0);
    wait_resp(r0 + 2);
    wait_gnt(gi, gd);
    chk("rr3_data", 32'(gd), 1);
    @(posedge clk); #1;
    data_req = 1'b0;
    wait_resp(r0 + 3);
    @(posedge clk); #1;

    // Instruction read at 0x80 with literal pad beats and 10-cycle latency.
    b0 = beats_seen; r0 = resp_seen;
    exp_beats.push_back(8'h3C); exp_beats.push_back(8'h80);
    exp_beats.push_back(8'h00); exp_beats.push_back(8'h00); exp_beats.push_back(8'h00);
    push_resp(0, 0, 32'h00000513);
    issue(0, 0, 4'hF, 32'h80, 32'h0, g);
    wait_beats(b0 + 5);
    respond(32'h00000513, -1, 0);
    wait_resp(r0 + 1);
    chk("rd_lat", 32'(rv_cyc - g), 10);
    @(posedge clk); #1;

    // Data write with a 3-cycle stall and stray inbound beats that must be ignored.
    b0 = beats_seen; r0 = resp_seen;
    exp_beats.push_back(8'h0F); exp_beats.push_back(8'h00); exp_beats.push_back(8'h10);
    exp_beats.push_back(8'h00); exp_beats.push_back(8'h00); exp_beats.push_back(8'hEF);
    exp_beats.push_back(8'hBE); exp_beats.push_back(8'hAD); exp_beats.push_back(8'hDE);
    push_resp(1, 0, 32'h0);
    issue(1, 1, 4'h3, 32'h1000, 32'hDEADBEEF, g);
    wait_beats(b0 + 3);
    @(posedge clk); #1;
    pad_out_ready = 1'b0; pad_in_valid = 1'b1; pad_in = '1;
    repeat (3) @(posedge clk); #1;
    pad_out_ready = 1'b1; pad_in_valid = 1'b0; pad_in = '0;
    wait_resp(r0 + 1);
    chk("wr_lat", 32'(rv_cyc - g), 32'(1 + HB + 2*NB + 3));
    chk("wr_beats", 32'(beats_seen - b0), 32'(HB + 2*NB));
    @(posedge clk); #1;

    // Silent read: timeout error, zero data.
    r0 = resp_seen;
    push_req(0, 0, 4'hF, 32'h100, 32'h0); push_resp(0, 1, 32'h0);
    issue(0, 0, 4'hF, 32'h100, 32'h0, g);
    wait_resp(r0 + 1);
    chk("to_lat", 32'(rv_cyc - g), 32'(1 + HB + NB + TIMEOUT));
    @(posedge clk); #1;

    // Slow response: gaps just under the timeout must not trip it.
    b0 = beats_seen; r0 = resp_seen;
    push_req(1, 0, 4'h5, 32'h2004, 32'h0); push_resp(1, 0, 32'hCAFEF00D);
    issue(1, 0, 4'h5, 32'h2004, 32'h0, g);
    wait_beats(b0 + HB + NB);
    respond(32'hCAFEF00D, -1, TIMEOUT - 2);
    wait_resp(r0 + 1);
    @(posedge clk); #1;

    // Reset during the address phase drops the transaction.
    b0 = beats_seen; r0 = resp_seen;
    push_req(0, 0, 4'hF, 32'h200, 32'h0);
    issue(0, 0, 4'hF, 32'h200, 32'h0, g);
    wait_beats(b0 + HB + 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_beats.delete();
    chk("mrst_pad_vld", 32'(pad_out_valid), 0);
    chk("mrst_pad_out", 32'(pad_out), 0);
    chk("mrst_rvalid", 32'({instr_rvalid, data_rvalid}), 0);
    c0 = cyc;
    b0 = beats_seen;
    push_req(0, 0, 4'hF, 32'h300, 32'h0); push_resp(0, 0, 32'h12345678);
    issue(0, 0, 4'hF, 32'h300, 32'h0, g);
    chk("mrst_gnt_now", 32'(g - c0), 0);
    wait_beats(b0 + HB + NB);
    respond(32'h12345678, -1, 0);
    wait_resp(r0 + 1);
    @(posedge clk); #1;

`ifdef IBEX_PAD_PARITY_EN
    // Corrupted parity on beat 3: all beats collected, then an error with zero data.
    b0 = beats_seen; r0 = resp_seen;
    push_req(0, 0, 4'hF, 32'h400, 32'h0); push_resp(0, 1, 32'h0);
    issue(0, 0, 4'hF, 32'h400, 32'h0, g);
    wait_beats(b0 + HB + NB);
    respond(32'h00000513, 3, 0);
    wait_resp(r0 + 1);
    chk("par_lat", 32'(rv_cyc - g), 32'(1 + HB + 2*NB));
    @(posedge clk); #1;
`endif

    repeat (4) @(posedge clk); #1;
    chk("beats_drained", 32'(exp_beats.size()), 0);
    chk("resps_drained", 32'(exp_resp.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ibex_pad_bridge.md
Name: ibex_pad_bridge

Overview:
- Pin-limited bridge between the ibex_top instruction and data OBI-style ports and a narrow off-chip pad bus.
- Each 32-bit request is serialized as header, address and write-data beats; each read response is deserialized from PAD_W-bit beats.
- Arbitrates between the instruction and data channels with one transaction outstanding, and times out unresponsive reads.
- Sits in the chip top between the ibex_top instance and the pads.

Parameters:
- PAD_W, 8, pad beat width; legal values 4, 8, 16, 32 (elaboration error otherwise).
- ARB_RR, 0, 0 = data channel has fixed priority; 1 = round-robin when both channels request in the same cycle.
- TIMEOUT, 256, max idle cycles between read-response beats before an error response; legal range 2..65535.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- instr_req_i  in  1  instruction request
- instr_addr_i  in  32  instruction address
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  32  instruction read data
- instr_err_o  out  1  instruction error
- data_req_i  in  1  data request
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data error
- pad_out_o  out  PAD_W  outbound beat
- pad_out_valid_o  out  1  outbound beat valid
- pad_out_ready_i  in  1  outbound beat accepted
- pad_in_i  in  PAD_W  inbound response beat
- pad_in_valid_i  in  1  inbound beat valid; no backpressure

Behaviour:
- Reset: synchronous, active-low. All outputs go to 0 and the FSM returns to IDLE. An in-flight transaction is dropped silently; no rvalid is issued for it.
- FSM states: IDLE, HDR, ADDR, WDATA, RESP, DONE.
- IDLE:
  - gnt_o is combinational and is asserted only in IDLE, only for the selected channel.
  - Selection with ARB_RR=0: data wins.
  - Selection with ARB_RR=1: the channel not granted last wins; the last-granted pointer resets to instr.
  - On the grant cycle, latch channel, we, be, addr and wdata, then go to HDR.
  - Instruction requests latch we=0, be=4'b1111.
- Header byte: bit0 = we, bit1 = channel (1 = data), bits5:2 = be, bits7:6 = 0.
- Beat counts:
  - HDR: ceil(8/PAD_W) beats; when PAD_W > 8 the header is zero-extended into one beat.
  - ADDR: 32/PAD_W beats.
  - WDATA (writes only): 32/PAD_W beats.
- All fields are sent LSB beat first.
- A beat transfers on pad_out_valid_o && pad_out_ready_i. pad_out_o and pad_out_valid_o are registered and stay stable while ready is low. A beat counter advances on each transfer.
- After the last ADDR beat: reads go to RESP; writes go to WDATA.
- After the last WDATA beat: go to DONE. No pad acknowledge is required for writes.
- RESP:
  - Each pad_in_valid_i cycle shifts one beat into the rdata assembly register, LSB first.
  - After 32/PAD_W beats, go to DONE.
  - The timeout counter clears on entry and on every accepted beat, and increments otherwise.
  - When the counter reaches TIMEOUT-1 with no beat, go to DONE with err=1 and rdata=0.
  - pad_in_valid_i outside RESP is ignored.
- DONE: assert rvalid_o for exactly one cycle on the latched channel, with rdata (0 for writes) and err; then go to IDLE.
- Requests arriving outside IDLE wait, since gnt stays low. A new grant is possible on the cycle after DONE.
- Latency:
  - Read: total = 1 grant cycle + HDR + ADDR beats + response beats + 1 DONE cycle.
  - Write: total = 1 grant cycle + HDR + ADDR beats + WDATA beats + 1 DONE cycle.
  - With PAD_W=8, always-ready pads and back-to-back response beats, a read's rvalid rises 10 cycles after gnt.

Optional Feature:
- Macro IBEX_PAD_PARITY_EN.
- When defined:
  - Adds ports pad_out_par_o (out, 1) and pad_in_par_i (in, 1), carrying even parity over each beat.
  - pad_out_par_o is registered alongside pad_out_o.
  - Any response beat with a parity mismatch sets a sticky error flag. The transaction still collects all beats and then completes with err=1 and rdata=0.
- When undefined: the parity ports are absent and no parity checking is done.

Test Plan:
- Instruction read, PAD_W=8, addr 0x80, ready=1 -> pad_out beats 0x3C, 0x80, 0x00, 0x00, 0x00; drive in-beats 0x13, 0x05, 0x00, 0x00 -> instr_rvalid_o=1 for 1 cycle, instr_rdata_o=0x00000513, err=0.
- Data write, be=0x3, addr 0x1000, wdata 0xDEADBEEF -> beats 0x0F, 0x00, 0x10, 0x00, 0x00, 0xEF, 0xBE, 0xAD, 0xDE; pad_out_ready_i low for 3 cycles mid-stream holds the current beat stable; data_rvalid_o=1 afterwards with err=0.
- Simultaneous instr and data requests in IDLE: ARB_RR=0 -> data granted first, instr second. ARB_RR=1, two consecutive contention rounds -> data granted, then instr.
- Read with no pad_in_valid_i, TIMEOUT=16 -> rvalid 16 cycles after RESP entry, err=1, rdata=0; next request is granted normally.
- rst_ni low for 1 cycle during the ADDR phase -> all outputs 0 the next cycle, no rvalid, FSM in IDLE; a following read completes correctly.
- PAD_W=4 instruction read of 0x00000513 -> 2 header beats, 8 address beats, 8 response beats, rdata correct. With IBEX_PAD_PARITY_EN, flipping pad_in_par_i on beat 3 -> err=1, rdata=0.
